divide: RTL and testbench
=========================

DIVIDE -- requirements
Module: divide

Interface
REQ-001 SHALL provide port clk, input, 1, single clock; all state updates on the rising edge.
REQ-002 SHALL provide port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-003 SHALL provide port LA, input, 1, load-enable for the dividend register from DataA.
REQ-004 SHALL provide port LB, input, 1, load-enable for the divisor register from DataB.
REQ-005 SHALL provide port s, input, 1, start request, level-sensitive.
REQ-006 SHALL provide port DataA, input, 32, unsigned dividend.
REQ-007 SHALL provide port DataB, input, 32, unsigned divisor.
REQ-008 SHALL provide port Q, output, 32, unsigned quotient.
REQ-009 SHALL provide port R, output, 32, unsigned remainder.
REQ-010 SHALL provide port Finish, output, 1, result valid.
REQ-011 SHALL provide port DivZero, output, 1, last operation had divisor 0.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 In IDLE, at a rising edge with LA=1, SHALL capture DataA into the dividend register; with LB=1, SHALL capture DataB into the divisor register; both may load on the same edge.
REQ-014 SHALL ignore LA and LB in RUN and DONE; operand registers hold.
REQ-015 In IDLE with s=1 and divisor≠0, SHALL enter RUN at the next edge, clear the partial remainder, load the working quotient register with the dividend, set the iteration counter to 31, and clear DivZero.
REQ-016 In IDLE with s=1 and divisor=0, SHALL go directly to DONE at the next edge with Q=32'hFFFFFFFF, R=dividend, DivZero=1.
REQ-017 In each RUN cycle SHALL perform one restoring-division step:
- shift {rem,quo} left one bit;
- form trial = rem_shifted − divisor (33-bit);
- if trial ≥ 0: rem = trial[31:0], quo[0] = 1;
- else: rem unchanged, quo[0] = 0.
REQ-018 SHALL decrement the counter each RUN cycle and enter DONE on the edge completing the step at counter 0: exactly 32 RUN cycles.
REQ-019 Latency SHALL be 33 edges from the edge sampling s=1 in IDLE to Finish=1 (1 start edge + 32 iterations); divide-by-zero latency SHALL be 1 edge.
REQ-020 Q and R SHALL update only on entry to DONE and hold their values through DONE, IDLE and the next RUN until the next DONE entry.
REQ-021 Finish SHALL be 1 exactly while in DONE and 0 in IDLE and RUN.
REQ-022 In DONE with s=1, SHALL remain in DONE (no restart); with s=0, SHALL return to IDLE at the next edge.
REQ-023 s deasserting during RUN SHALL NOT abort or alter the operation.
REQ-024 The result SHALL satisfy dividend = Q·divisor + R with R < divisor for every divisor≠0, including dividend=0 and dividend < divisor.

Reset
REQ-025 reset=0 SHALL immediately, independent of clk, force IDLE and clear the dividend, divisor, working, counter, Q, R, Finish and DivZero registers to 0.
REQ-026 Reset asserted during RUN or DONE SHALL abandon the operation; after release the block SHALL be in IDLE awaiting a new load and start.
REQ-027 The first rising edge after reset release SHALL be processed normally as an IDLE cycle.

Verification
REQ-028 Load A=156, B=12, pulse s -> Finish=1 exactly 33 edges after s is sampled; Q=13, R=0, DivZero=0.
REQ-029 Load A=123, B=156, start -> Q=0, R=123; then A=32'hFFFFFFFF, B=1 -> Q=32'hFFFFFFFF, R=0; then A=32'hFFFFFFFF, B=32'h10000 -> Q=32'h0000FFFF, R=32'hFFFF.
REQ-030 Load A=77, B=0, start -> Finish=1 one edge later, DivZero=1, Q=32'hFFFFFFFF, R=77.
REQ-031 Hold s=1 for 50 edges after Finish; change DataA/DataB and pulse LA/LB during RUN and DONE -> state stays DONE, Q/R unchanged; drop s -> IDLE next edge, Finish=0.
REQ-032 Start A=1000, B=7; assert reset at iteration 10 -> all outputs 0 immediately; release, reload A=1000, B=7, start -> Q=142, R=6.
REQ-033 Random regression: at least 1000 random unsigned pairs, including B=1, B=A, B>A, and A=0, checked against a reference model for Q, R and the 33-edge latency.

Source files
------------

// File: rtl/divide.sv
// 32-bit unsigned restoring divider: one quotient bit per cycle, 33-edge latency,
// single-edge divide-by-zero path.
module divide (
  input  logic        clk,
  input  logic        reset,
  input  logic        LA,
  input  logic        LB,
  input  logic        s,
  input  logic [31:0] DataA,
  input  logic [31:0] DataB,
  output logic [31:0] Q,
  output logic [31:0] R,
  output logic        Finish,
  output logic        DivZero
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] dividend_q, dividend_d;
  logic [31:0] divisor_q, divisor_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] q_q, q_d;
  logic [31:0] r_q, r_d;
  logic        finish_q, finish_d;
  logic        divzero_q, divzero_d;

  // One restoring step; rem < divisor always holds, so a negative trial means
  // the shifted remainder still fits in 32 bits.
  logic [32:0] rem_sh;
  logic [32:0] trial;
  logic [31:0] rem_step;
  logic [31:0] quo_step;

  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    trial  = rem_sh - {1'b0, divisor_q};
    if (!trial[32]) begin
      rem_step = trial[31:0];
      quo_step = {quo_q[30:0], 1'b1};
    end else begin
      rem_step = rem_sh[31:0];
      quo_step = {quo_q[30:0], 1'b0};
    end
  end

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    q_d        = q_q;
    r_d        = r_q;
    divzero_d  = divzero_q;

    unique case (state_q)
      StIdle: begin
        if (LA) dividend_d = DataA;
        if (LB) divisor_d = DataB;
        if (s) begin
          if (divisor_q == 32'd0) begin
            state_d   = StDone;
            q_d       = 32'hFFFF_FFFF;
            r_d       = dividend_q;
            divzero_d = 1'b1;
          end else begin
            state_d   = StRun;
            rem_d     = 32'd0;
            quo_d     = dividend_q;
            cnt_d     = 5'd31;
            divzero_d = 1'b0;
          end
        end
      end
      StRun: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = StDone;
          q_d     = quo_step;
          r_d     = rem_step;
        end
      end
      StDone: begin
        if (!s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    finish_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      dividend_q <= 32'd0;
      divisor_q  <= 32'd0;
      rem_q      <= 32'd0;
      quo_q      <= 32'd0;
      cnt_q      <= 5'd0;
      q_q        <= 32'd0;
      r_q        <= 32'd0;
      finish_q   <= 1'b0;
      divzero_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
      r_q        <= r_d;
      finish_q   <= finish_d;
      divzero_q  <= divzero_d;
    end
  end

  assign Q       = q_q;
  assign R       = r_q;
  assign Finish  = finish_q;
  assign DivZero = divzero_q;

endmodule

// File: tb/tb_divide.sv
// Directed and randomised checks of the divider: results, latency, hold behaviour, reset.
module tb_divide;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        LA = 1'b0, LB = 1'b0, s = 1'b0;
  logic [31:0] DataA = '0, DataB = '0;
  logic [31:0] Q, R;
  logic        Finish, DivZero;

  int n_checks = 0;
  int n_pass = 0;

  divide dut (
    .clk    (clk),
    .reset  (reset),
    .LA     (LA),
    .LB     (LB),
    .s      (s),
    .DataA  (DataA),
    .DataB  (DataB),
    .Q      (Q),
    .R      (R),
    .Finish (Finish),
    .DivZero(DivZero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Loads operands, pulses s, and checks latency plus results against the expectations.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input string tag);
    int edges;
    int exp_lat;
    exp_lat = (b == 32'd0) ? 1 : 33;
    @(negedge clk);
    DataA = a; DataB = b; LA = 1'b1; LB = 1'b1;
    @(negedge clk);
    LA = 1'b0; LB = 1'b0; s = 1'b1;
    @(negedge clk);
    s = 1'b0;
    edges = 1;
    while (!Finish && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check({tag, ".lat"}, edges, exp_lat);
    check({tag, ".Q"}, Q, eq);
    check({tag, ".R"}, R, er);
    check({tag, ".dz"}, {31'd0, DivZero}, {31'd0, b == 32'd0});
    @(negedge clk);
    check({tag, ".idle"}, {31'd0, Finish}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, b, q0, r0;
    int edges;
    int held_bad;

    #12;
    check("rst.Q", Q, 32'd0);
    check("rst.R", R, 32'd0);
    check("rst.fin", {31'd0, Finish}, 32'd0);
    check("rst.dz", {31'd0, DivZero}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_div(32'd156, 32'd12, 32'd13, 32'd0, "d156_12");
    run_div(32'd123, 32'd156, 32'd0, 32'd123, "d123_156");
    run_div(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, "dmax_1");
    run_div(32'hFFFF_FFFF, 32'h1_0000, 32'h0000_FFFF, 32'h0000_FFFF, "dmax_64k");
    run_div(32'd77, 32'd0, 32'hFFFF_FFFF, 32'd77, "dz77");
    run_div(32'd0, 32'd5, 32'd0, 32'd0, "d0_5");

    // s held through RUN and DONE while operand loads are attempted.
    @(negedge clk);
    DataA = 32'd100; DataB = 32'd9; LA = 1'b1; LB = 1'b1;
    @(negedge clk);
    LA = 1'b0; LB = 1'b0; s = 1'b1;
    @(negedge clk);
    edges = 1;
    while (!Finish && edges < 40) begin
      DataA = 32'd5000 + edges; DataB = 32'd3; LA = edges[0]; LB = ~edges[0];
      @(negedge clk);
      edges++;
    end
    check("hold.lat", edges, 33);
    check("hold.Q", Q, 32'd11);
    check("hold.R", R, 32'd1);
    held_bad = 0;
    for (int i = 0; i < 50; i++) begin
      DataA = 32'd7 * i; DataB = 32'd2; LA = 1'b1; LB = 1'b1;
      @(negedge clk);
      if (!Finish || Q !== 32'd11 || R !== 32'd1) held_bad++;
    end
    check("hold.done50", held_bad, 0);
    LA = 1'b0; LB = 1'b0; s = 1'b0;
    @(negedge clk);
    check("hold.drop", {31'd0, Finish}, 32'd0);
    // Operands must be the originals since loads were ignored outside IDLE.
    @(negedge clk);
    s = 1'b1;
    @(negedge clk);
    s = 1'b0;
    edges = 1;
    while (!Finish && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check("hold.rerun.Q", Q, 32'd11);
    check("hold.rerun.R", R, 32'd1);
    @(negedge clk);

    // Reset mid-run.
    @(negedge clk);
    DataA = 32'd1000; DataB = 32'd7; LA = 1'b1; LB = 1'b1;
    @(negedge clk);
    LA = 1'b0; LB = 1'b0; s = 1'b1;
    @(negedge clk);
    s = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("amid.Q", Q, 32'd0);
    check("amid.R", R, 32'd0);
    check("amid.fin", {31'd0, Finish}, 32'd0);
    check("amid.dz", {31'd0, DivZero}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_div(32'd1000, 32'd7, 32'd142, 32'd6, "d1000_7");

    // Randomised regression with a behavioural reference.
    for (int i = 0; i < 1000; i++) begin
      unique case (i % 5)
        0: begin a = $urandom; b = 32'd1; end
        1: begin a = $urandom; if (a == 32'd0) a = 32'd5; b = a; end
        2: begin a = $urandom_range(0, 1000); b = a + 32'd1 + $urandom_range(0, 1000); end
        3: begin a = 32'd0; b = $urandom | 32'd1; end
        default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
      endcase
      if (b == 32'd0) begin
        q0 = 32'hFFFF_FFFF; r0 = a;
      end else begin
        q0 = a / b; r0 = a % b;
      end
      run_div(a, b, q0, r0, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
